// File: rtl/attempt_lockout_ctrl_if.sv
// Signal bundle between the safe-lock supervisor, the code comparator,
// the interval timer and the bolt/LED drivers.
interface attempt_lockout_ctrl_if #(
  parameter int CNT_W = 2
);
  logic             code_valid;
  logic             code_match;
  logic             relock;
  logic             admin_clear;
  logic             timer_done;
  logic             timer_start;
  logic             unlocked;
  logic             lockout;
  logic             alarm;
  logic [CNT_W-1:0] fail_count;
  logic [CNT_W-1:0] lockout_count;

  modport master (
    output code_valid, code_match, relock, admin_clear, timer_done,
    input  timer_start, unlocked, lockout, alarm, fail_count, lockout_count
  );

  modport slave (
    input  code_valid, code_match, relock, admin_clear, timer_done,
    output timer_start, unlocked, lockout, alarm, fail_count, lockout_count
  );
endinterface

// File: rtl/attempt_lockout_ctrl.sv
// Safe-lock supervisor: counts wrong codes, times the open window and the
// penalty lockout through the shared interval timer, latches a tamper alarm.
module attempt_lockout_ctrl #(
  parameter int MAX_ATTEMPTS = 3,
  parameter int MAX_LOCKOUTS = 2,
  parameter int CNT_W        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  attempt_lockout_ctrl_if.slave bus
);

  localparam logic [2:0] S_LOCKED   = 3'd0;
  localparam logic [2:0] S_OPEN_ARM = 3'd1;
  localparam logic [2:0] S_OPEN     = 3'd2;
  localparam logic [2:0] S_LOCK_ARM = 3'd3;
  localparam logic [2:0] S_LOCKOUT  = 3'd4;
  localparam logic [2:0] S_ALARM    = 3'd5;

  localparam logic [CNT_W-1:0] FAIL_LAST = CNT_W'(MAX_ATTEMPTS - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCKOUTS - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] fail_q;
  logic [CNT_W-1:0] lock_q;

  always_ff @(posedge clk) begin
    if (rst || bus.admin_clear) begin
      state  <= S_LOCKED;
      fail_q <= '0;
      lock_q <= '0;
    end else begin
      case (state)
        S_LOCKED: begin
          if (bus.code_valid) begin
            if (bus.code_match) begin
              state  <= S_OPEN_ARM;
              fail_q <= '0;
              lock_q <= '0;
            end else if (fail_q < FAIL_LAST) begin
              fail_q <= fail_q + CNT_W'(1);
            end else begin
              fail_q <= '0;
              // Final lockout escalates straight to alarm without arming the timer.
              if (lock_q == LOCK_LAST) begin
                state <= S_ALARM;
              end else begin
                lock_q <= lock_q + CNT_W'(1);
                state  <= S_LOCK_ARM;
              end
            end
          end
        end
        // Timer still reports done during ARM, so ARM states never look at it.
        S_OPEN_ARM: state <= S_OPEN;
        S_OPEN: begin
          if (bus.timer_done || bus.relock) state <= S_LOCKED;
        end
        S_LOCK_ARM: state <= S_LOCKOUT;
        S_LOCKOUT: begin
          if (bus.timer_done) state <= S_LOCKED;
        end
        S_ALARM: state <= S_ALARM;
        default: state <= S_LOCKED;
      endcase
    end
  end

  assign bus.timer_start   = (state == S_OPEN_ARM) || (state == S_LOCK_ARM);
  assign bus.unlocked      = (state == S_OPEN_ARM) || (state == S_OPEN);
  assign bus.lockout       = (state == S_LOCK_ARM) || (state == S_LOCKOUT);
  assign bus.alarm         = (state == S_ALARM);
  assign bus.fail_count    = fail_q;
  assign bus.lockout_count = lock_q;

endmodule

// File: doc/attempt_lockout_ctrl.md
Name: attempt_lockout_ctrl

Overview:
- Safe-lock supervisory FSM. It consumes each code-entry verdict (valid pulse plus match flag) and counts failed attempts.
- It drives the team's interval timer (start pulse out, done in) to time both the unlocked window and the penalty lockout.
- It escalates to a latched alarm after repeated lockouts.
- It sits between the code comparator (upstream) and the interval timer / bolt driver / status LEDs (downstream).

Parameters:
- MAX_ATTEMPTS, 3, consecutive wrong codes that trigger a lockout; range 1..2^CNT_W.
- MAX_LOCKOUTS, 2, lockouts without an intervening unlock that trigger the alarm; range 1..2^CNT_W.
- CNT_W, 2, width of fail_count and lockout_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- code_valid  in  1  one-cycle pulse: a complete code has been entered.
- code_match  in  1  qualifies code_valid; 1 = correct code.
- relock  in  1  user request to relock while open; level, sampled each cycle.
- admin_clear  in  1  supervisor override: abort lockout or alarm, zero the counters.
- timer_done  in  1  interval timer countdown is at zero.
- timer_start  out  1  one-cycle reload request to the interval timer.
- unlocked  out  1  bolt release.
- lockout  out  1  penalty-lockout indicator.
- alarm  out  1  latched tamper alarm.
- fail_count  out  CNT_W  current consecutive wrong attempts.
- lockout_count  out  CNT_W  lockouts since the last unlock or clear.

Behaviour:
- One clock and one reset. The clock is clk; the reset is rst, which is synchronous and active-high. rst has top priority.
- On reset:
  - state goes to LOCKED.
  - Every output is 0, including fail_count and lockout_count.
- States: LOCKED, OPEN_ARM, OPEN, LOCK_ARM, LOCKOUT, ALARM.
- Outputs are Moore decodes of the registered state, plus the two counter registers:
  - timer_start = (OPEN_ARM | LOCK_ARM).
  - unlocked = (OPEN_ARM | OPEN).
  - lockout = (LOCK_ARM | LOCKOUT).
  - alarm = ALARM.
- LOCKED, with code_valid & code_match:
  - go to OPEN_ARM.
  - fail_count <= 0, lockout_count <= 0.
- LOCKED, with code_valid & !code_match:
  - If fail_count < MAX_ATTEMPTS-1: fail_count++ and stay in LOCKED.
  - Otherwise: fail_count <= 0.
  - Then, if lockout_count == MAX_LOCKOUTS-1: go to ALARM (no timer_start) and lockout_count holds.
  - Else: lockout_count++ and go to LOCK_ARM.
- OPEN_ARM and LOCK_ARM each last exactly 1 cycle, then move unconditionally to OPEN or LOCKOUT respectively.
  - timer_done is ignored in ARM states, because the timer still reports done until it samples start.
- OPEN: timer_done=1 or relock=1 -> LOCKED (auto-relock). relock is ignored in OPEN_ARM.
- LOCKOUT: timer_done=1 -> LOCKED; fail_count stays 0.
- ALARM: held until admin_clear or rst.
- code_valid outside LOCKED is discarded: not counted and no state change.
- admin_clear (below rst, above everything else), in any state:
  - state <= LOCKED.
  - Both counters <= 0.
  - Any code_valid in the same cycle is discarded.
  - The timer is left running and is re-armed on the next ARM entry.
- Timing with a 10-cycle timer:
  - ARM in cycle t; timer loads at the end of t.
  - timer_done = 0 in cycles t+1..t+10 and = 1 at t+11.
  - The FSM leaves at the end of t+11, so the unlocked/lockout window is 12 cycles (t..t+11).
- Counters never wrap: fail_count <= MAX_ATTEMPTS-1 and lockout_count <= MAX_LOCKOUTS-1 always.
- Reset mid-operation (any state) returns LOCKED with zeroed counters in the next cycle. No pending timer_start is issued.

Test Plan:
1. Assert rst for 2 cycles with code_valid=1 -> all outputs 0, fail_count=0; first post-reset cycle is LOCKED.
2. Correct code at cycle 0, bench instantiates the real interval timer (reload 10) -> timer_start=1 in cycle 1 only; unlocked=1 in cycles 1..12 and 0 in cycle 13; fail_count=0.
3. Three wrong codes, 5 cycles apart:
   - fail_count goes 1, 2, then 0.
   - lockout_count=1; lockout=1 for 12 cycles with one timer_start pulse.
   - A correct code during the lockout is ignored, and unlocked stays 0.
4. Three more wrong codes (lockout_count=1) -> alarm=1, no timer_start, lockout=0. Alarm holds for 30 cycles under repeated correct codes. admin_clear -> LOCKED next cycle, alarm=0, counters 0.
5. Unlock, then relock=1 in the 3rd OPEN cycle -> unlocked=0 next cycle. In LOCKED, admin_clear together with a wrong code_valid -> fail_count stays 0.
6. Assert rst in the 4th LOCKOUT cycle -> lockout=0 next cycle, counters 0, state LOCKED. A correct code then unlocks normally: a fresh timer_start and a 12-cycle window.
